// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder.
// Lane-mask helper is also used by the M stage.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } resp_state_t;

  function automatic logic [3:0] lane_mask(
    input msize_t     size,
    input logic [1:0] addr
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (size)
      MSIZE1:  m = 4'b0001 << addr;
      MSIZE2:  m = addr[1] ? 4'b1100 : 4'b0011;
      MSIZE4:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dbus_sram_responder_check.sv
// Combinational request check: alignment and strobe/size agreement.
// Produces the expected lane mask alongside the verdict.
module dbus_req_check
  import dbus_sram_responder_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  msize_t     size,
  input  logic [3:0] strobe,
  output logic       ok,
  output logic [3:0] mask
);

  logic aligned;

  always_comb begin
    aligned = 1'b0;
    mask    = lane_mask(size, addr_lo);
    unique case (1'b1)
      (size == MSIZE4): aligned = (addr_lo == 2'b00);
      (size == MSIZE2): aligned = !addr_lo[0];
      (size == MSIZE1): aligned = 1'b1;
      default:          aligned = 1'b0;
    endcase
    ok = aligned && ((strobe == 4'b0000) || (strobe == mask));
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: one request at a time into a synchronous SRAM
// with LATENCY-cycle reads; full word returned on a one-cycle data_ok.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dreq_valid,
  input  logic [31:0]       dreq_addr,
  input  msize_t            dreq_size,
  input  logic [3:0]        dreq_strobe,
  input  logic [31:0]       dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [31:0]       dresp_data,
  output logic              dresp_err,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("dbus_sram_responder: LATENCY must be >= 1");
    end
  endgenerate

  resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       resp_q;

  logic              req_ok;
  logic [3:0]        req_mask;
  logic [3:0]        req_we;
  logic              accept;
  logic              resp;
  logic              unused_addr;

  assign unused_addr = ^dreq_addr[31:ADDR_W+2];

  dbus_req_check u_check (
    .addr_lo (dreq_addr[1:0]),
    .size    (dreq_size),
    .strobe  (dreq_strobe),
    .ok      (req_ok),
    .mask    (req_mask)
  );

  assign req_we = (dreq_strobe != 4'b0000) ? req_mask : 4'b0000;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq_valid) begin
          accept  = 1'b1;
          state_d = req_ok ? ISSUE : RESP;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      we_q    <= 4'b0000;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      resp_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          err_q  <= 1'b0;
          resp_q <= 32'h0;
          if (dreq_valid) begin
            waddr_q <= dreq_addr[ADDR_W+1:2];
            we_q    <= req_we;
            wdata_q <= dreq_data;
            err_q   <= !req_ok;
          end
        end
        ISSUE: cnt_q <= CNT_W'(LATENCY);
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // writes return a zero word
          if (cnt_q == CNT_W'(1))
            resp_q <= (we_q == 4'b0000) ? sram_rdata : 32'h0;
        end
        default: ;
      endcase
    end
  end

  // reset must silence the handshake even while valid is held
  assign dresp_addr_ok = accept && resetn;
  assign dresp_data_ok = resp;
  assign dresp_data    = resp ? resp_q : 32'h0;
  assign dresp_err     = resp && err_q;

  assign sram_en    = (state_q == ISSUE);
  assign sram_we    = (state_q == ISSUE) ? we_q : 4'b0000;
  assign sram_addr  = waddr_q;
  assign sram_wdata = wdata_q;

endmodule
